// File: rtl/bus_pkg.sv
// Shared definitions for the bus_param shared-bus controller: active-low levels,
// read/write encodings, default widths, arbiter state type and a clog2 helper.
package bus_pkg;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;

    localparam int DEF_NUM_M   = 4;
    localparam int DEF_NUM_S   = 8;
    localparam int DEF_AW      = 30;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/bus_param_if.sv
// Bundle of master-side and slave-side bus signals around the bus_param controller.
// The master modport is the controller's view; slave is the mirrored agent view.
interface bus_param_if #(
    parameter int NUM_M = 4,
    parameter int NUM_S = 8,
    parameter int AW    = 30,
    parameter int DW    = 32
);
    logic [NUM_M-1:0]    m_req_;
    logic [NUM_M-1:0]    m_grnt_;
    logic [NUM_M*AW-1:0] m_addr;
    logic [NUM_M-1:0]    m_as_;
    logic [NUM_M-1:0]    m_rw;
    logic [NUM_M*DW-1:0] m_wr_data;
    logic [DW-1:0]       m_rd_data;
    logic                m_rdy_;
    logic                m_err;
    logic [AW-1:0]       s_addr;
    logic                s_as_;
    logic                s_rw;
    logic [DW-1:0]       s_wr_data;
    logic [NUM_S-1:0]    s_cs_;
    logic [NUM_S*DW-1:0] s_rd_data;
    logic [NUM_S-1:0]    s_rdy_;

    modport master (
        input  m_req_, m_addr, m_as_, m_rw, m_wr_data, s_rd_data, s_rdy_,
        output m_grnt_, m_rd_data, m_rdy_, m_err,
               s_addr, s_as_, s_rw, s_wr_data, s_cs_
    );

    modport slave (
        output m_req_, m_addr, m_as_, m_rw, m_wr_data, s_rd_data, s_rdy_,
        input  m_grnt_, m_rd_data, m_rdy_, m_err,
               s_addr, s_as_, s_rw, s_wr_data, s_cs_
    );

endinterface

// File: rtl/bus_rr_arbiter.sv
// Registered round-robin arbiter: an owner keeps the bus while its request is held,
// and on release the search restarts just past the last owner.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter  int NUM_M = 4,
    localparam int MW    = clog2(NUM_M)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NUM_M-1:0] req_n_i,
    output logic [NUM_M-1:0] grnt_n_o,
    output logic [MW-1:0]    owner_o,
    output logic             ownerValid_o
);

    localparam logic [NUM_M-1:0] ONE = NUM_M'(1);

    arb_state_e       state_q;
    logic [MW-1:0]    owner_q;
    logic [MW-1:0]    last_q;
    logic [NUM_M-1:0] grnt_q;

    logic             found;
    logic [MW-1:0]    pick;
    logic [MW-1:0]    cand;

    // Last owner is searched last, so it only wins again when nobody else asks.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        cand  = last_q;
        for (int i = 1; i <= NUM_M; i++) begin
            cand = MW'((int'(last_q) + i) % NUM_M);
            if (!found && req_n_i[cand] == ENABLE_) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= MW'(NUM_M - 1);
            grnt_q  <= '1;
        end else if (state_q == ARB_IDLE || req_n_i[owner_q] == DISABLE_) begin
            if (found) begin
                state_q <= ARB_OWNED;
                owner_q <= pick;
                last_q  <= pick;
                grnt_q  <= ~(ONE << pick);
            end else begin
                state_q <= ARB_IDLE;
                grnt_q  <= '1;
            end
        end
    end

    assign grnt_n_o     = grnt_q;
    assign owner_o      = owner_q;
    assign ownerValid_o = (state_q == ARB_OWNED);

endmodule

// File: rtl/bus_param.sv
// Shared-bus controller: round-robin arbiter, master mux, address decode and slave mux.
// Define BUS_TIMEOUT_EN to add the watchdog that terminates unanswered transfers with m_err.
module bus_param
    import bus_pkg::*;
#(
    parameter int NUM_M   = DEF_NUM_M,
    parameter int NUM_S   = DEF_NUM_S,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic         clk,
    input logic         reset,
    bus_param_if.master bus
);

    localparam int MW = clog2(NUM_M);
    localparam int SW = clog2(NUM_S);

    logic [NUM_M-1:0] grntN;
    logic [MW-1:0]    owner;
    logic             ownerValid;

    logic [AW-1:0]    sAddr;
    logic             sAs;
    logic             sRw;
    logic [DW-1:0]    sWrData;
    logic [SW-1:0]    slaveIdx;
    logic [NUM_S-1:0] csN;
    logic [DW-1:0]    selRdData;
    logic             selRdy;

    bus_rr_arbiter #(.NUM_M(NUM_M)) u_arbiter (
        .clk          (clk),
        .reset        (reset),
        .req_n_i      (bus.m_req_),
        .grnt_n_o     (grntN),
        .owner_o      (owner),
        .ownerValid_o (ownerValid)
    );

    always_comb begin
        sAddr   = '0;
        sAs     = DISABLE_;
        sRw     = READ;
        sWrData = '0;
        if (ownerValid) begin
            sAddr   = bus.m_addr[owner*AW +: AW];
            sAs     = bus.m_as_[owner];
            sRw     = bus.m_rw[owner];
            sWrData = bus.m_wr_data[owner*DW +: DW];
        end
    end

    // Top address bits pick the slave; indices beyond NUM_S simply match nothing.
    assign slaveIdx = sAddr[AW-1 -: SW];

    always_comb begin
        csN       = '1;
        selRdData = '0;
        selRdy    = DISABLE_;
        for (int j = 0; j < NUM_S; j++) begin
            if (sAs == ENABLE_ && slaveIdx == SW'(j)) begin
                csN[j]    = ENABLE_;
                selRdData = bus.s_rd_data[j*DW +: DW];
                selRdy    = bus.s_rdy_[j];
            end
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CW = 16;

    logic [CW-1:0] wdCnt_q;
    logic [CW-1:0] wdCnt_d;
    logic          waiting;
    logic          wdFire;

    // A slave answering on the limit cycle clears waiting, so the real ready wins.
    assign waiting = (sAs == ENABLE_) && (selRdy == DISABLE_);
    assign wdFire  = waiting && (wdCnt_q == CW'(TIMEOUT));
    assign wdCnt_d = (waiting && !wdFire) ? wdCnt_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdCnt_q <= '0;
        end else begin
            wdCnt_q <= wdCnt_d;
        end
    end

    assign bus.m_rdy_    = wdFire ? ENABLE_ : selRdy;
    assign bus.m_err     = wdFire;
    assign bus.m_rd_data = wdFire ? '0 : selRdData;
`else
    assign bus.m_rdy_    = selRdy;
    assign bus.m_err     = 1'b0;
    assign bus.m_rd_data = selRdData;
`endif

    assign bus.m_grnt_   = grntN;
    assign bus.s_addr    = sAddr;
    assign bus.s_as_     = sAs;
    assign bus.s_rw      = sRw;
    assign bus.s_wr_data = sWrData;
    assign bus.s_cs_     = csN;

endmodule
